unified_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's two requesters: instruction fetch (IF) and data access (MEM stage). It sequences one transaction at a time over a request/acknowledge memory handshake and returns read data and per-requester done strobes. It drives stall signals that freeze the IF front end and the whole pipeline while accesses are pending. It sits beside the hazard unit; its stall outputs are ORed into pcWrite/ifidWrite and the pipeline-register enables.

---
 rtl/unified_mem_arbiter_if.sv | 30 +++
 rtl/unified_mem_arbiter.sv | 62 ++++++
 tb/tb_unified_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: requester, memory and stall signals of the unified memory arbiter
interface unified_mem_arbiter_if;
  logic ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic ifDone;
  logic memRd;
  logic memWr;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic memDone;
  logic uReq;
  logic uWe;
  logic [31:0] uAddr;
  logic [31:0] uWdata;
  logic [31:0] uRdata;
  logic uAck;
  logic stallIf;
  logic stallAll;
  logic errFlag;
  modport slave (
    input  ifReq, ifAddr, memRd, memWr, memAddr, memWdata, uRdata, uAck,
    output ifRdata, ifDone, memRdata, memDone, uReq, uWe, uAddr, uWdata, stallIf, stallAll, errFlag
  );
  modport master (
    output ifReq, ifAddr, memRd, memWr, memAddr, memWdata, uRdata, uAck,
    input  ifRdata, ifDone, memRdata, memDone, uReq, uWe, uAddr, uWdata, stallIf, stallAll, errFlag
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between instruction fetch and the MEM stage
module unified_mem_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 64
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
  state_t state;
  logic [3:0] fair_cnt;
  logic [7:0] to_cnt;
  logic mem_req, busy, tmo, fin, grant_mem;
  assign mem_req   = bus.memRd | bus.memWr;
  assign busy      = state != IDLE;
  assign tmo       = busy & ~bus.uAck & (to_cnt == 8'(TIMEOUT - 1));
  assign fin       = busy & (bus.uAck | tmo);
  assign grant_mem = mem_req & ~(bus.ifReq & (fair_cnt == 4'(FAIR_LIMIT)));
  // a dropped request (e.g. fetch flush) still completes on the bus but never strobes done
  assign bus.ifDone   = rst & (state == BUSY_IF) & fin & bus.ifReq;
  assign bus.memDone  = rst & (state == BUSY_MEM) & fin & mem_req;
  assign bus.ifRdata  = (bus.ifDone & bus.uAck & ~bus.uWe) ? bus.uRdata : 32'd0;
  assign bus.memRdata = (bus.memDone & bus.uAck & ~bus.uWe) ? bus.uRdata : 32'd0;
  assign bus.stallAll = rst & mem_req & ~bus.memDone;
  assign bus.stallIf  = rst & (bus.stallAll | (bus.ifReq & ~bus.ifDone));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      bus.uReq    <= 1'b0;
      bus.uWe     <= 1'b0;
      bus.uAddr   <= 32'd0;
      bus.uWdata  <= 32'd0;
      bus.errFlag <= 1'b0;
      fair_cnt    <= 4'd0;
      to_cnt      <= 8'd0;
    end else if (state == IDLE) begin
      if (grant_mem) begin
        state      <= BUSY_MEM;
        bus.uReq   <= 1'b1;
        bus.uWe    <= bus.memWr;
        bus.uAddr  <= bus.memAddr;
        bus.uWdata <= bus.memWr ? bus.memWdata : 32'd0;
        to_cnt     <= 8'd0;
        fair_cnt   <= !bus.ifReq ? 4'd0 : (fair_cnt == 4'(FAIR_LIMIT)) ? fair_cnt : fair_cnt + 4'd1;
      end else if (bus.ifReq) begin
        state      <= BUSY_IF;
        bus.uReq   <= 1'b1;
        bus.uWe    <= 1'b0;
        bus.uAddr  <= bus.ifAddr;
        bus.uWdata <= 32'd0;
        to_cnt     <= 8'd0;
        fair_cnt   <= 4'd0;
      end
    end else if (fin) begin
      state       <= IDLE;
      bus.uReq    <= 1'b0;
      bus.errFlag <= bus.errFlag | tmo;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed scoreboard bench for the unified memory arbiter
module tb_unified_mem_arbiter;
  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;
  txn_t q[$];
  unified_mem_arbiter_if bus ();
  unified_mem_arbiter #(.FAIR_LIMIT(4), .TIMEOUT(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_if, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.is_if = is_if;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    q.push_back(t);
  endtask

  task automatic wait_req(output txn_t t);
    int n = 0;
    tick();
    while (!bus.uReq && n < 20) begin
      tick();
      n++;
    end
    chk("ureq_grant", 32'(bus.uReq), 32'd1);
    t = '{is_if: 1'b0, we: 1'b0, addr: 32'd0, wdata: 32'd0};
    if (q.size() > 0) begin
      t = q.pop_front();
      chk("uwe", 32'(bus.uWe), 32'(t.we));
      chk("uaddr", bus.uAddr, t.addr);
      chk("uwdata", bus.uWdata, t.wdata);
      chk(t.is_if ? "stall_if_wait" : "stall_all_wait", 32'(t.is_if ? bus.stallIf : bus.stallAll), 32'd1);
    end else begin
      chk("sb_underflow", 32'(q.size()), 32'd1);
    end
  endtask

  task automatic serve(input int lat, input logic [31:0] rd);
    txn_t t;
    wait_req(t);
    repeat (lat - 1) tick();
    bus.uRdata = rd;
    bus.uAck   = 1'b1;
    #1;
    if (t.is_if) begin
      chk("if_done", 32'(bus.ifDone), 32'd1);
      chk("if_rdata", bus.ifRdata, rd);
      chk("mem_done_quiet", 32'(bus.memDone), 32'd0);
    end else begin
      chk("mem_done", 32'(bus.memDone), 32'd1);
      chk("mem_rdata", bus.memRdata, t.we ? 32'd0 : rd);
      chk("stall_all_done", 32'(bus.stallAll), 32'd0);
    end
    tick();
    bus.uAck   = 1'b0;
    bus.uRdata = 32'd0;
  endtask

  initial begin
    txn_t t;
    int early;
    bus.ifReq = 0; bus.ifAddr = 0; bus.memRd = 0; bus.memWr = 0;
    bus.memAddr = 0; bus.memWdata = 0; bus.uRdata = 0; bus.uAck = 0;
    repeat (2) tick();
    chk("rst_ureq", 32'(bus.uReq), 32'd0);
    chk("rst_uaddr", bus.uAddr, 32'd0);
    chk("rst_err", 32'(bus.errFlag), 32'd0);
    chk("rst_stall_if", 32'(bus.stallIf), 32'd0);
    rst = 1'b1;
    tick();
    // single fetch
    bus.ifReq = 1; bus.ifAddr = 32'h40;
    push(1, 0, 32'h40, 0);
    #1 chk("fetch_stall_if", 32'(bus.stallIf), 32'd1);
    serve(1, 32'h8C220004);
    bus.ifReq = 0;
    #1 chk("fetch_stall_if_after", 32'(bus.stallIf), 32'd0);
    chk("fetch_ureq_after", 32'(bus.uReq), 32'd0);
    // store vs fetch contention: MEM first, then IF
    bus.memWr = 1; bus.memAddr = 32'h100; bus.memWdata = 32'hCAFE0001;
    bus.ifReq = 1; bus.ifAddr = 32'h44;
    push(0, 1, 32'h100, 32'hCAFE0001);
    push(1, 0, 32'h44, 0);
    #1 chk("cont_stall_all", 32'(bus.stallAll), 32'd1);
    serve(2, 32'h0);
    bus.memWr = 0;
    #1 chk("cont_stall_all_clear", 32'(bus.stallAll), 32'd0);
    chk("cont_stall_if_held", 32'(bus.stallIf), 32'd1);
    serve(1, 32'h11112222);
    bus.ifReq = 0;
    // fairness: M,M,M,M,I,M then a further I
    bus.memRd = 1; bus.memAddr = 32'h200;
    bus.ifReq = 1; bus.ifAddr = 32'h80;
    for (int i = 0; i < 6; i++) push(i == 4, 0, (i == 4) ? 32'h80 : 32'h200, 0);
    for (int i = 0; i < 6; i++) serve(2, 32'h1000 + 32'(i));
    bus.memRd = 0;
    push(1, 0, 32'h80, 0);
    serve(1, 32'h2000);
    bus.ifReq = 0;
    // timeout with no acknowledge
    bus.memRd = 1; bus.memAddr = 32'h300;
    push(0, 0, 32'h300, 0);
    wait_req(t);
    early = 0;
    repeat (63) begin
      if (bus.memDone) early++;
      tick();
    end
    chk("to_early_done", 32'(early), 32'd0);
    chk("to_done", 32'(bus.memDone), 32'd1);
    chk("to_rdata", bus.memRdata, 32'd0);
    tick();
    bus.memRd = 0;
    chk("to_err_set", 32'(bus.errFlag), 32'd1);
    chk("to_idle", 32'(bus.uReq), 32'd0);
    bus.memRd = 1; bus.memAddr = 32'h304;
    push(0, 0, 32'h304, 0);
    serve(1, 32'hABCD);
    bus.memRd = 0;
    chk("to_err_sticky", 32'(bus.errFlag), 32'd1);
    // flush mid-fetch
    bus.ifReq = 1; bus.ifAddr = 32'h90;
    push(1, 0, 32'h90, 0);
    wait_req(t);
    tick();
    bus.ifReq = 0;
    tick();
    tick();
    bus.uAck = 1; bus.uRdata = 32'hDEAD0000;
    #1 chk("flush_no_done", 32'(bus.ifDone), 32'd0);
    chk("flush_rdata", bus.ifRdata, 32'd0);
    chk("flush_stall_if", 32'(bus.stallIf), 32'd0);
    tick();
    bus.uAck = 0; bus.uRdata = 0;
    chk("flush_idle", 32'(bus.uReq), 32'd0);
    bus.ifReq = 1; bus.ifAddr = 32'h94;
    push(1, 0, 32'h94, 0);
    serve(1, 32'h5555AAAA);
    bus.ifReq = 0;
    // async reset mid BUSY_MEM
    bus.memWr = 1; bus.memAddr = 32'h400; bus.memWdata = 32'h77;
    push(0, 1, 32'h400, 32'h77);
    wait_req(t);
    #2 rst = 1'b0;
    #1 chk("arst_ureq", 32'(bus.uReq), 32'd0);
    chk("arst_stall_all", 32'(bus.stallAll), 32'd0);
    chk("arst_err", 32'(bus.errFlag), 32'd0);
    chk("arst_done", 32'(bus.memDone), 32'd0);
    bus.memWr = 0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("arst_idle_ureq", 32'(bus.uReq), 32'd0);
    chk("arst_idle_stall", 32'(bus.stallIf), 32'd0);
    bus.ifReq = 1; bus.ifAddr = 32'h98;
    push(1, 0, 32'h98, 0);
    serve(1, 32'h12345678);
    bus.ifReq = 0;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
